bilinear_scan_ctrl: RTL and testbench
=====================================

BILINEAR_SCAN_CTRL -- requirements
Module: bilinear_scan_ctrl

Interface
REQ-001 SHALL have parameters: INDEX_WIDTH, default 16, width of coordinates and frame sizes; INT_WIDTH, default 8, integer bits of scale factor; FIX_WIDTH, default 12, fraction bits of scale factor; CALC_LATENCY, default 3, pipeline depth of the downstream source-coordinate calculator.
REQ-002 SHALL have ports, in this order:
- clk_i, in, 1: the single clock.
- rst_i, in, 1: asynchronous, active-low reset.
- start_i, in, 1: frame start request.
- abort_i, in, 1: stop issuing coordinates immediately.
- dest_width_i, in, INDEX_WIDTH: output frame width in pixels.
- dest_height_i, in, INDEX_WIDTH: output frame height in pixels.
- scale_factorx_i, in, INT_WIDTH+FIX_WIDTH: horizontal scale factor.
- scale_factory_i, in, INT_WIDTH+FIX_WIDTH: vertical scale factor.
- issue_ready_i, in, 1: downstream can accept a result CALC_LATENCY cycles later.
- destx_o, out, INDEX_WIDTH: x coordinate presented to the calculator.
- desty_o, out, INDEX_WIDTH: y coordinate presented to the calculator.
- scale_factorx_o, out, INT_WIDTH+FIX_WIDTH: latched horizontal scale factor.
- scale_factory_o, out, INT_WIDTH+FIX_WIDTH: latched vertical scale factor.
- src_valid_o, out, 1: calculator output is valid this cycle.
- sof_o, out, 1: first pixel of frame; aligned with src_valid_o.
- eol_o, out, 1: last pixel of a line; aligned with src_valid_o.
- eof_o, out, 1: last pixel of frame; aligned with src_valid_o.
- busy_o, out, 1: controller is not IDLE.
- done_o, out, 1: one-cycle frame-complete pulse.
- cfg_err_o, out, 1: one-cycle pulse on a rejected start.

Function
REQ-003 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE + start_i=1 + both dims nonzero: SHALL latch dims and scale factors, set x=y=0, and enter RUN next cycle.
REQ-005 IDLE + start_i=1 + either dim zero: SHALL pulse cfg_err_o for 1 cycle and remain in IDLE.
REQ-006 start_i outside IDLE SHALL be ignored; latched config SHALL stay stable until the next accepted start.
REQ-007 Issue condition: RUN and issue_ready_i=1. On issue, destx_o/desty_o SHALL hold the current coordinate, and the counters SHALL advance on the next edge.
REQ-008 RUN with issue_ready_i=0 SHALL hold destx_o/desty_o and issue nothing; there is no partial state.
REQ-009 Scan order SHALL be raster. x increments; at x=width-1, x wraps to 0 and y increments. Issuing (width-1, height-1) SHALL transition to DRAIN.
REQ-010 Each issue SHALL push a tag {valid, sof, eol, eof} into a CALC_LATENCY-deep shift register. The tap SHALL drive src_valid_o/sof_o/eol_o/eof_o exactly CALC_LATENCY cycles after the issue cycle.
REQ-011 sof SHALL be set for (0,0), eol for x=width-1, eof for (width-1, height-1). A 1x1 frame SHALL assert all three on one beat.
REQ-012 DRAIN SHALL count CALC_LATENCY cycles, then go to DONE. DONE SHALL assert done_o for 1 cycle and return to IDLE.
REQ-013 abort_i in RUN SHALL suppress issue in that cycle and enter DRAIN. In-flight tags SHALL still emerge; eof SHALL not be generated for the unfinished frame. abort_i in other states SHALL be ignored.
REQ-014 busy_o SHALL be 1 in RUN, DRAIN and DONE.
REQ-015 Counter compares SHALL use full INDEX_WIDTH. width=2^INDEX_WIDTH-1 SHALL not overflow the x counter.
REQ-016 Throughput SHALL be 1 coordinate per cycle while issue_ready_i=1, including across line wrap.

Reset
REQ-017 rst_i low SHALL asynchronously force IDLE and clear: counters, latched config, the tag shift register, and all outputs to 0.
REQ-018 Reset mid-frame SHALL discard in-flight tags; no done_o SHALL be produced. Release SHALL be synchronised so the FSM leaves reset on a clock edge.

Structure
REQ-019 A shared package SHALL hold: the FSM state enum, the tag bit-field layout, and default widths consistent with the calculator.
REQ-020 The tag delay line SHALL be a sub-module, bilinear_tag_delay (parameter depth and width, async active-low clear).
REQ-021 The block SHALL be instantiable directly beside cal_bilinear_srcxy, sharing INDEX_WIDTH, INT_WIDTH and FIX_WIDTH.

Verification
REQ-022 Width 4, height 2, scale 0x1800 (1.5), ready held high -> 8 issues: (0,0)...(3,1) consecutive. src_valid 8 cycles starting 3 after first issue; sof on beat 0; eol on beats 3 and 7; eof on beat 7; done_o 3 cycles after last issue +1.
REQ-023 Width 3, height 1, issue_ready_i toggling 1,0,1,0,1 -> exactly 3 valid beats, each 3 cycles after its issue; coordinates not skipped.
REQ-024 start_i with width 0 -> cfg_err_o pulse, busy_o stays 0; start with width 1, height 1 -> single beat with sof, eol and eof all 1.
REQ-025 abort_i at 5th issue cycle of a 4x4 frame -> 4 valid beats, no eof, done_o after drain; new start then accepted.
REQ-026 rst_i low during RUN of a 4x4 frame -> all outputs 0 immediately; no further src_valid_o or done_o after release.

Source files
------------

// File: rtl/bilinear_scan_ctrl_pkg.sv
// Shared definitions for the bilinear scan controller: FSM states, the
// per-beat tag layout and default widths matching cal_bilinear_srcxy.
package bilinear_scan_ctrl_pkg;

   localparam int DEF_INDEX_WIDTH  = 16;
   localparam int DEF_INT_WIDTH    = 8;
   localparam int DEF_FIX_WIDTH    = 12;
   localparam int DEF_CALC_LATENCY = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // One tag travels alongside every issued coordinate.
   typedef struct packed {
      logic valid;
      logic sof;
      logic eol;
      logic eof;
   } tag_t;

   localparam int TAG_WIDTH = $bits(tag_t);

endpackage

// File: rtl/bilinear_scan_ctrl_tag_delay.sv
// Fixed-depth delay line that re-times issue tags to the calculator output.
module bilinear_tag_delay #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_d;
   logic [DEPTH-1:0][WIDTH-1:0] stage_q;

   // Shift by one stage per clock; stage 0 takes the newly issued tag.
   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = din_i;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Clearing on reset drops every in-flight tag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stage_q <= '0;
      else         stage_q <= stage_d;
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bilinear_scan_ctrl.sv
// Raster scan controller feeding destination coordinates to the bilinear
// source-coordinate calculator and re-aligning frame markers to its output.
module bilinear_scan_ctrl
   import bilinear_scan_ctrl_pkg::*;
#(
   parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
   parameter int INT_WIDTH    = DEF_INT_WIDTH,
   parameter int FIX_WIDTH    = DEF_FIX_WIDTH,
   parameter int CALC_LATENCY = DEF_CALC_LATENCY
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   input  logic                           abort_i,
   input  logic [INDEX_WIDTH-1:0]         dest_width_i,
   input  logic [INDEX_WIDTH-1:0]         dest_height_i,
   input  logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factorx_i,
   input  logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factory_i,
   input  logic                           issue_ready_i,
   output logic [INDEX_WIDTH-1:0]         destx_o,
   output logic [INDEX_WIDTH-1:0]         desty_o,
   output logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factorx_o,
   output logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factory_o,
   output logic                           src_valid_o,
   output logic                           sof_o,
   output logic                           eol_o,
   output logic                           eof_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           cfg_err_o
);

   localparam int SF_W   = INT_WIDTH + FIX_WIDTH;
   localparam int DCNT_W = $clog2(CALC_LATENCY + 1);
   localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(CALC_LATENCY - 1);

   logic [1:0]             rst_sync_d, rst_sync_q;
   logic                   rst_n;
   state_e                 state_d, state_q;
   logic [INDEX_WIDTH-1:0] x_d, x_q, y_d, y_q;
   logic [INDEX_WIDTH-1:0] width_d, width_q, height_d, height_q;
   logic [SF_W-1:0]        sfx_d, sfx_q, sfy_d, sfy_q;
   logic [DCNT_W-1:0]      drain_d, drain_q;
   logic                   cfg_err_d, cfg_err_q;
   logic                   last_x, last_y;
   tag_t                   tag_in, tag_out;

   // Reset asserts asynchronously but releases only on a clock edge.
   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   // Two-flop reset release synchroniser.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) rst_sync_q <= '0;
      else        rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   // Next-state, counter advance and tag generation.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      width_d   = width_q;
      height_d  = height_q;
      sfx_d     = sfx_q;
      sfy_d     = sfy_q;
      drain_d   = drain_q;
      cfg_err_d = 1'b0;
      tag_in    = '0;
      last_x    = (x_q == width_q - INDEX_WIDTH'(1));
      last_y    = (y_q == height_q - INDEX_WIDTH'(1));
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if ((dest_width_i != '0) && (dest_height_i != '0)) begin
                  width_d  = dest_width_i;
                  height_d = dest_height_i;
                  sfx_d    = scale_factorx_i;
                  sfy_d    = scale_factory_i;
                  x_d      = '0;
                  y_d      = '0;
                  state_d  = ST_RUN;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort_i) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end else if (issue_ready_i) begin
               tag_in.valid = 1'b1;
               tag_in.sof   = (x_q == '0) && (y_q == '0);
               tag_in.eol   = last_x;
               tag_in.eof   = last_x && last_y;
               if (last_x) begin
                  x_d = '0;
                  if (last_y) begin
                     state_d = ST_DRAIN;
                     drain_d = '0;
                  end else begin
                     y_d = y_q + INDEX_WIDTH'(1);
                  end
               end else begin
                  x_d = x_q + INDEX_WIDTH'(1);
               end
            end
         end
         ST_DRAIN: begin
            // Wait out the calculator pipeline so the last tag emerges first.
            if (drain_q == DRAIN_LAST) state_d = ST_DONE;
            else                       drain_d = drain_q + DCNT_W'(1);
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state, counters and latched frame configuration.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         width_q   <= '0;
         height_q  <= '0;
         sfx_q     <= '0;
         sfy_q     <= '0;
         drain_q   <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         width_q   <= width_d;
         height_q  <= height_d;
         sfx_q     <= sfx_d;
         sfy_q     <= sfy_d;
         drain_q   <= drain_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   bilinear_tag_delay #(
      .DEPTH (CALC_LATENCY),
      .WIDTH (TAG_WIDTH)
   ) u_tag_delay (
      .clk_i  (clk_i),
      .rst_ni (rst_n),
      .din_i  (tag_in),
      .dout_o (tag_out)
   );

   assign destx_o         = x_q;
   assign desty_o         = y_q;
   assign scale_factorx_o = sfx_q;
   assign scale_factory_o = sfy_q;
   assign src_valid_o     = tag_out.valid;
   assign sof_o           = tag_out.sof;
   assign eol_o           = tag_out.eol;
   assign eof_o           = tag_out.eof;
   assign busy_o          = (state_q != ST_IDLE);
   assign done_o          = (state_q == ST_DONE);
   assign cfg_err_o       = cfg_err_q;

endmodule

// File: tb/tb_bilinear_scan_ctrl.sv
// Directed bench for bilinear_scan_ctrl with a tag scoreboard.
module tb_bilinear_scan_ctrl;

   localparam int IW  = 16;
   localparam int NI  = 8;
   localparam int NF  = 12;
   localparam int LAT = 3;
   localparam int SW  = NI + NF;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic          issue_ready_i = 1'b0;
   logic [IW-1:0] dest_width_i = '0;
   logic [IW-1:0] dest_height_i = '0;
   logic [SW-1:0] sfx_i = '0;
   logic [SW-1:0] sfy_i = '0;

   logic [IW-1:0] destx_o, desty_o;
   logic [SW-1:0] scale_factorx_o, scale_factory_o;
   logic          src_valid_o, sof_o, eol_o, eof_o, busy_o, done_o, cfg_err_o;

   bilinear_scan_ctrl #(
      .INDEX_WIDTH  (IW),
      .INT_WIDTH    (NI),
      .FIX_WIDTH    (NF),
      .CALC_LATENCY (LAT)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .abort_i         (abort_i),
      .dest_width_i    (dest_width_i),
      .dest_height_i   (dest_height_i),
      .scale_factorx_i (sfx_i),
      .scale_factory_i (sfy_i),
      .issue_ready_i   (issue_ready_i),
      .destx_o         (destx_o),
      .desty_o         (desty_o),
      .scale_factorx_o (scale_factorx_o),
      .scale_factory_o (scale_factory_o),
      .src_valid_o     (src_valid_o),
      .sof_o           (sof_o),
      .eol_o           (eol_o),
      .eof_o           (eof_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .cfg_err_o       (cfg_err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         due;
      logic [2:0] tag;
   } exp_t;

   exp_t sb[$];
   logic mon_ev;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Output side of the scoreboard: a beat is expected exactly when the head entry is due.
   always @(negedge clk) begin
      mon_ev = (sb.size() > 0) && (sb[0].due == cyc);
      chk("src_valid", 64'(src_valid_o), 64'(mon_ev));
      if (mon_ev) begin
         chk("beat_tag", 64'({sof_o, eol_o, eof_o}), 64'(sb[0].tag));
         void'(sb.pop_front());
      end else begin
         chk("idle_tag", 64'({sof_o, eol_o, eof_o}), 64'(0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input int w, input int h, input logic [SW-1:0] sx, input logic [SW-1:0] sy);
      dest_width_i  = IW'(w);
      dest_height_i = IW'(h);
      sfx_i         = sx;
      sfy_i         = sy;
      start_i       = 1'b1;
      tick();
      start_i       = 1'b0;
   endtask

   // Expects an issue this cycle; queues its tag for LAT cycles later.
   task automatic issue(input int x, input int y, input logic s, input logic e, input logic f);
      @(negedge clk);
      chk("destx", 64'(destx_o), 64'(x));
      chk("desty", 64'(desty_o), 64'(y));
      chk("busy_run", 64'(busy_o), 64'(1));
      sb.push_back('{due: cyc + LAT, tag: {s, e, f}});
      tick();
   endtask

   task automatic finish_frame(input int drain_cycles);
      for (int i = 0; i < drain_cycles; i++) begin
         @(negedge clk);
         chk("busy_drain", 64'(busy_o), 64'(1));
         chk("done_early", 64'(done_o), 64'(0));
         tick();
      end
      @(negedge clk);
      chk("done_pulse", 64'(done_o), 64'(1));
      chk("busy_done", 64'(busy_o), 64'(1));
      tick();
      @(negedge clk);
      chk("done_clear", 64'(done_o), 64'(0));
      chk("busy_idle", 64'(busy_o), 64'(0));
      chk("sb_empty", 64'(sb.size()), 64'(0));
      tick();
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_dest"}, 64'({destx_o, desty_o}), 64'(0));
      chk({name, "_sf"}, 64'({scale_factorx_o, scale_factory_o}), 64'(0));
      chk({name, "_flags"}, 64'({src_valid_o, sof_o, eol_o, eof_o, busy_o, done_o, cfg_err_o}), 64'(0));
   endtask

   initial begin
      // Power-on reset
      repeat (3) tick();
      chk_all_zero("reset");
      rst_i = 1'b1;
      repeat (3) tick();

      // 4x2 frame, ready held high
      start_frame(4, 2, 20'h01800, 20'h02000);
      issue_ready_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         issue(k % 4, k / 4, k == 0, (k % 4) == 3, k == 7);
      end
      chk("sfx_latched", 64'(scale_factorx_o), 64'(20'h01800));
      chk("sfy_latched", 64'(scale_factory_o), 64'(20'h02000));
      finish_frame(LAT);

      // 3x1 frame with ready toggling; start and abort outside their states ignored
      start_frame(3, 1, 20'h00C00, 20'h01000);
      issue_ready_i = 1'b1;
      issue(0, 0, 1'b1, 1'b0, 1'b0);
      issue_ready_i = 1'b0;
      start_i       = 1'b1;
      dest_width_i  = IW'(7);
      sfx_i         = 20'h0ABCD;
      @(negedge clk);
      chk("hold_x1", 64'(destx_o), 64'(1));
      chk("sfx_stable", 64'(scale_factorx_o), 64'(20'h00C00));
      tick();
      start_i       = 1'b0;
      issue_ready_i = 1'b1;
      issue(1, 0, 1'b0, 1'b0, 1'b0);
      issue_ready_i = 1'b0;
      @(negedge clk);
      chk("hold_x2", 64'(destx_o), 64'(2));
      tick();
      issue_ready_i = 1'b1;
      issue(2, 0, 1'b0, 1'b1, 1'b1);
      abort_i = 1'b1;
      finish_frame(LAT);
      abort_i = 1'b0;

      // Rejected starts: zero width, then zero height
      for (int k = 0; k < 2; k++) begin
         dest_width_i  = (k == 0) ? IW'(0) : IW'(3);
         dest_height_i = (k == 0) ? IW'(5) : IW'(0);
         start_i = 1'b1;
         tick();
         start_i = 1'b0;
         @(negedge clk);
         chk("cfg_err_pulse", 64'(cfg_err_o), 64'(1));
         chk("cfg_err_busy", 64'(busy_o), 64'(0));
         tick();
         @(negedge clk);
         chk("cfg_err_clear", 64'(cfg_err_o), 64'(0));
         chk("cfg_err_sfx", 64'(scale_factorx_o), 64'(20'h00C00));
         tick();
      end

      // 1x1 frame: single beat carrying sof, eol and eof
      start_frame(1, 1, 20'h01000, 20'h01000);
      issue(0, 0, 1'b1, 1'b1, 1'b1);
      finish_frame(LAT);

      // 4x4 frame aborted on the fifth issue cycle
      start_frame(4, 4, 20'h01800, 20'h01800);
      for (int k = 0; k < 4; k++) begin
         issue(k, 0, k == 0, k == 3, 1'b0);
      end
      abort_i = 1'b1;
      @(negedge clk);
      chk("busy_abort", 64'(busy_o), 64'(1));
      tick();
      abort_i = 1'b0;
      finish_frame(LAT);

      // New start after the abort
      start_frame(2, 1, 20'h00800, 20'h00800);
      issue(0, 0, 1'b1, 1'b0, 1'b0);
      issue(1, 0, 1'b0, 1'b1, 1'b1);
      finish_frame(LAT);

      // Reset in the middle of a 4x4 frame
      start_frame(4, 4, 20'h01800, 20'h01800);
      issue(0, 0, 1'b1, 1'b0, 1'b0);
      issue(1, 0, 1'b0, 1'b0, 1'b0);
      issue(2, 0, 1'b0, 1'b0, 1'b0);
      sb.delete();
      rst_i = 1'b0;
      #1;
      chk_all_zero("midrst");
      repeat (3) tick();
      rst_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("postrst_done", 64'(done_o), 64'(0));
         chk("postrst_busy", 64'(busy_o), 64'(0));
         tick();
      end
      issue_ready_i = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
